// File: rtl/prim_clock_gate_ctrl_if.sv
// Handshake bundle between a gating requester and the clock-gate controller.
interface prim_clock_gate_ctrl_if #(
  parameter int CntW = 16
) ();
  logic            gate_req_i;
  logic            idle_i;
  logic            wake_i;
  logic            en_o;
  logic            gated_o;
  logic            armed_o;
  logic [CntW-1:0] gate_cnt_o;

  modport master (
    output gate_req_i, idle_i, wake_i,
    input  en_o, gated_o, armed_o, gate_cnt_o
  );

  modport slave (
    input  gate_req_i, idle_i, wake_i,
    output en_o, gated_o, armed_o, gate_cnt_o
  );
endinterface

// File: rtl/prim_clock_gate_ctrl.sv
// Drives the enable of one clock-gating cell: gates after a held request plus a run of
// idle cycles, un-gates on request release or wake, and counts gating events.
module prim_clock_gate_ctrl #(
  parameter int IdleCycles = 4,
  parameter int WakeCycles = 2,
  parameter int CntW       = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  prim_clock_gate_ctrl_if.slave bus
);
  localparam logic [1:0] ST_ON    = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OFF   = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam int CntMax = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
  localparam int TW     = $clog2(CntMax + 1);
  localparam logic [TW-1:0] IdleLast = TW'(IdleCycles - 1);
  localparam logic [TW-1:0] WakeLast = TW'(WakeCycles - 1);

  logic [1:0]      state, state_d;
  logic [TW-1:0]   cnt, cnt_d;
  logic            armed, armed_d;
  logic [CntW-1:0] gate_cnt, gate_cnt_d;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    armed_d    = armed;
    gate_cnt_d = gate_cnt;
    if (!bus.gate_req_i) armed_d = 1'b1;
    case (state)
      ST_ON: begin
        if (bus.gate_req_i && armed) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (!bus.gate_req_i) begin
          state_d = ST_ON;
        end else if (!bus.idle_i) begin
          cnt_d = '0;
        end else if (cnt == IdleLast) begin
          state_d = ST_OFF;
          if (gate_cnt != '1) gate_cnt_d = gate_cnt + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_OFF: begin
        if (bus.wake_i || !bus.gate_req_i) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
          // A wake while still requested disarms, so the requester must toggle to re-gate.
          if (bus.wake_i && bus.gate_req_i) armed_d = 1'b0;
        end
      end
      ST_WAKE: begin
        if (cnt == WakeLast) state_d = ST_ON;
        else                 cnt_d   = cnt + 1'b1;
      end
      default: state_d = ST_ON;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_ON;
      cnt      <= '0;
      armed    <= 1'b1;
      gate_cnt <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      armed    <= armed_d;
      gate_cnt <= gate_cnt_d;
    end
  end

  assign bus.en_o       = (state != ST_OFF);
  assign bus.gated_o    = (state == ST_OFF) || (state == ST_WAKE);
  assign bus.armed_o    = armed;
  assign bus.gate_cnt_o = gate_cnt;
endmodule
